pipe_skid_latch: RTL and testbench

//  Parametrised elastic pipeline register between processor stages.

---
 rtl/pipe_skid_latch_pkg.sv | 15 +
 rtl/pipe_skid_latch_reg_bank.sv | 27 ++
 rtl/pipe_skid_latch.sv | 146 ++++++++++++++
 tb/tb_pipe_skid_latch.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_latch_pkg.sv
// Shared definitions for the elastic stage latches: occupancy encodings and
// the default bubble instruction placed on channel 0 when a stage is empty.
package pipe_skid_latch_pkg;

  // Occupancy doubles as the control state: entries currently held.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  // Default bubble instruction shared by every stage latch.
  localparam logic [31:0] DEFAULT_NOP_IR = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_latch_reg_bank.sv
// W-bit storage register with load enable and asynchronous clear to INIT.
// Used for both the main (head) and the skid entry of the stage latch.
module pipe_skid_latch_reg_bank #(
  parameter int           W    = 32,
  parameter logic [W-1:0] INIT = {W{1'b0}}
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold the entry; load when enabled, clear to INIT on reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= INIT;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Elastic pipeline register between processor stages: NCH channels of WIDTH
// bits, valid/ready handshake, one skid entry so in_ready never depends
// combinationally on out_ready, and a synchronous flush that leaves a bubble.
// The main register always holds either the head entry or the bubble, so
// out_data comes straight from a flop.
module pipe_skid_latch
  import pipe_skid_latch_pkg::*;
#(
  parameter int          WIDTH  = 32,
  parameter int          NCH    = 3,
  parameter logic [31:0] NOP_IR = DEFAULT_NOP_IR
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [1:0]           occupancy
);

  localparam int               DW      = NCH * WIDTH;
  // Channel 0 bubble: NOP_IR truncated (or zero-extended) to WIDTH bits.
  localparam logic [WIDTH-1:0] NOP_CH0 = WIDTH'(NOP_IR);
  // Full bubble: NOP on channel 0, all other channels zero.
  localparam logic [DW-1:0]    BUBBLE  = DW'(NOP_CH0);

  occ_e          r_state;
  occ_e          w_state_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_acc;
  logic          w_con;
  logic          w_main_en;
  logic          w_skid_en;
  logic [DW-1:0] w_main_d;
  logic [DW-1:0] w_skid_d;
  logic [DW-1:0] w_main_q;
  logic [DW-1:0] w_skid_q;

  assign w_acc = in_valid & r_in_ready;
  assign w_con = r_out_valid & out_ready;

  // Next occupancy and register load selection; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_main_d    = BUBBLE;
    w_skid_en   = 1'b0;
    w_skid_d    = BUBBLE;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
      w_main_en   = 1'b1;
      w_skid_en   = 1'b1;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = OCC_MAIN;
            w_main_en   = 1'b1;
            w_main_d    = in_data;
          end else begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_MAIN: begin
          if (w_acc && w_con) begin
            w_state_nxt = OCC_MAIN;
            w_main_en   = 1'b1;
            w_main_d    = in_data;
          end else if (w_acc) begin
            w_state_nxt = OCC_SKID;
            w_skid_en   = 1'b1;
            w_skid_d    = in_data;
          end else if (w_con) begin
            // Head leaves with nothing behind it: main falls back to bubble.
            w_state_nxt = OCC_EMPTY;
            w_main_en   = 1'b1;
          end else begin
            w_state_nxt = OCC_MAIN;
          end
        end
        OCC_SKID: begin
          if (w_con) begin
            // Skid entry advances to the head; skid returns to bubble.
            w_state_nxt = OCC_MAIN;
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
            w_skid_en   = 1'b1;
          end else begin
            w_state_nxt = OCC_SKID;
          end
        end
        default: begin
          w_state_nxt = OCC_EMPTY;
          w_main_en   = 1'b1;
          w_skid_en   = 1'b1;
        end
      endcase
    end
  end

  // Control FSM with registered handshake flags derived from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != OCC_SKID);
      r_out_valid <= (w_state_nxt != OCC_EMPTY);
    end
  end

  pipe_skid_latch_reg_bank #(
    .W    (DW),
    .INIT (BUBBLE)
  ) u_main (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_en      (w_main_en),
    .i_d       (w_main_d),
    .o_q       (w_main_q)
  );

  pipe_skid_latch_reg_bank #(
    .W    (DW),
    .INIT (BUBBLE)
  ) u_skid (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_en      (w_skid_en),
    .i_d       (w_skid_d),
    .o_q       (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed and random test of pipe_skid_latch. A depth-2 FIFO scoreboard
// predicts occupancy, handshake flags and the head entry for two instances:
// the default configuration and NCH=5 / WIDTH=16 / NOP_IR=16'h0013.
module tb_pipe_skid_latch;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [95:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [79:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [95:0] q_a[$];
  logic [95:0] q_b[$];

  localparam logic [95:0] BUB_A = 96'h0;
  localparam logic [95:0] BUB_B = 96'h13;

  pipe_skid_latch u_dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
  );

  pipe_skid_latch #(
    .WIDTH  (16),
    .NCH    (5),
    .NOP_IR (32'h0000_0013)
  ) u_dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on instance s (0=default, 1=NCH5): check outputs against the
  // model, drive inputs, update the model, advance to 1 time unit past the edge.
  task automatic step(input bit s, input logic fl, input logic iv,
                      input logic [95:0] id, input logic ordy);
    int          sz;
    logic [95:0] head;
    logic        acc, con;
    if (!s) begin
      sz   = q_a.size();
      head = (sz != 0) ? q_a[0] : BUB_A;
      chk("a_occupancy", 96'(a_occ), 96'(sz));
      chk("a_in_ready", 96'(a_in_ready), 96'(sz != 2));
      chk("a_out_valid", 96'(a_out_valid), 96'(sz != 0));
      chk("a_out_data", a_out_data, head);
      a_flush = fl; a_in_valid = iv; a_in_data = id; a_out_ready = ordy;
    end else begin
      sz   = q_b.size();
      head = (sz != 0) ? q_b[0] : BUB_B;
      chk("b_occupancy", 96'(b_occ), 96'(sz));
      chk("b_in_ready", 96'(b_in_ready), 96'(sz != 2));
      chk("b_out_valid", 96'(b_out_valid), 96'(sz != 0));
      chk("b_out_data", 96'(b_out_data), head);
      b_flush = fl; b_in_valid = iv; b_in_data = id[79:0]; b_out_ready = ordy;
    end
    acc = iv && (sz != 2);
    con = (sz != 0) && ordy;
    if (!s) begin
      if (fl) q_a.delete();
      else begin
        if (con) void'(q_a.pop_front());
        if (acc) q_a.push_back(id);
      end
    end else begin
      if (fl) q_b.delete();
      else begin
        if (con) void'(q_b.pop_front());
        if (acc) q_b.push_back({16'h0, id[79:0]});
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [95:0] rnd;
    reset_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 96'h0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 80'h0; b_out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Streaming: one entry per cycle, ch0 = 1,2,3,...
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 1'b1, 96'(i), 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);

    // Stall/skid: A then B with out_ready low; C rejected while full.
    step(1'b0, 1'b0, 1'b1, 96'hAAAA_0000_0000_0000_0000_000A, 1'b1);
    step(1'b0, 1'b0, 1'b1, 96'hBBBB_0000_0000_0000_0000_000B, 1'b0);
    step(1'b0, 1'b0, 1'b1, 96'hCCCC_0000_0000_0000_0000_000C, 1'b0);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);

    // Flush while full, with a same-cycle valid C and consume.
    step(1'b0, 1'b0, 1'b1, 96'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 96'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 96'hC0FFEE, 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);

    // Asynchronous reset mid-stream with both stages full.
    step(1'b0, 1'b0, 1'b1, 96'h33, 1'b0);
    step(1'b0, 1'b0, 1'b1, 96'h44, 1'b0);
    step(1'b1, 1'b0, 1'b1, 96'h55, 1'b0);
    step(1'b1, 1'b0, 1'b1, 96'h66, 1'b0);
    chk("pre_reset_occ", 96'(a_occ), 96'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_occupancy", 96'(a_occ), 96'd0);
    chk("rst_out_valid", 96'(a_out_valid), 96'd0);
    chk("rst_in_ready", 96'(a_in_ready), 96'd1);
    chk("rst_out_data", a_out_data, BUB_A);
    chk("rst_b_occupancy", 96'(b_occ), 96'd0);
    chk("rst_b_out_data", 96'(b_out_data), BUB_B);
    q_a.delete();
    q_b.delete();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, 1'b0, 96'h0, 1'b1);

    // NCH=5 / WIDTH=16 instance: directed bubble check then random run.
    step(1'b1, 1'b0, 1'b0, 96'h0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      step(1'b1, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
           rnd, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 96'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
